// File: rtl/mmio_regfile_p.sv
// Memory-mapped register file with two combinational read ports and write-through bypass.
// Includes a synchronised external-input register, a sticky W1C event register and an export window.
module mmio_regfile_p #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned EXT_REG     = 29,
    parameter int unsigned EVT_REG     = 30,
    parameter int unsigned EXPORT_BASE = 10,
    parameter int unsigned NUM_EXPORT  = 13
) (
    input  logic                             clock,
    input  logic                             ctrl_reset,
    input  logic                             ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]            ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]            data_writeReg,
    input  logic [ADDR_WIDTH-1:0]            ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0]            ctrl_readRegB,
    output logic [DATA_WIDTH-1:0]            data_readRegA,
    output logic [DATA_WIDTH-1:0]            data_readRegB,
    input  logic [DATA_WIDTH-1:0]            external_inputs,
    output logic [NUM_EXPORT*DATA_WIDTH-1:0] export_bus,
    output logic [NUM_EXPORT-1:0]            export_update,
    output logic                             event_pending
);

    localparam int unsigned NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] EXT_IDX = ADDR_WIDTH'(EXT_REG);
    localparam logic [ADDR_WIDTH-1:0] EVT_IDX = ADDR_WIDTH'(EVT_REG);

    localparam bit CFG_OK =
        (EXT_REG != 0) && (EVT_REG != 0) && (EXT_REG < NUM_REGS) && (EVT_REG < NUM_REGS) &&
        (EXT_REG != EVT_REG) && (NUM_EXPORT > 0) && (EXPORT_BASE != 0) &&
        (EXPORT_BASE + NUM_EXPORT <= NUM_REGS) &&
        !((EXT_REG >= EXPORT_BASE) && (EXT_REG < EXPORT_BASE + NUM_EXPORT)) &&
        !((EVT_REG >= EXPORT_BASE) && (EVT_REG < EXPORT_BASE + NUM_EXPORT));

    if (!CFG_OK) begin : g_bad_cfg
        $error("mmio_regfile_p: EXT_REG, EVT_REG and export window must be distinct, non-zero and in range");
    end

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] sync1_q, sync2_q, ext_prev_q;
    logic [DATA_WIDTH-1:0] evt_q, evt_d, evt_clr;
    logic [NUM_EXPORT-1:0] export_update_q, export_update_d;
    logic                  gen_we;
    logic                  bypass;

    assign gen_we = ctrl_writeEnable && (ctrl_writeReg != '0) &&
                    (ctrl_writeReg != EXT_IDX) && (ctrl_writeReg != EVT_IDX);
    assign bypass = gen_we && !ctrl_reset;

    // ext_prev_q delays edge detection by one cycle, so events appear one edge after EXT_REG rises
    always_comb begin
        evt_clr = '0;
        if (ctrl_writeEnable && (ctrl_writeReg == EVT_IDX)) begin
            evt_clr = data_writeReg;
        end
        evt_d = (evt_q & ~evt_clr) | (sync2_q & ~ext_prev_q);
    end

    always_comb begin
        export_update_d = '0;
        for (int unsigned k = 0; k < NUM_EXPORT; k++) begin
            if (gen_we && (ctrl_writeReg == ADDR_WIDTH'(EXPORT_BASE + k))) begin
                export_update_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            sync1_q         <= '0;
            sync2_q         <= '0;
            ext_prev_q      <= '0;
            evt_q           <= '0;
            export_update_q <= '0;
        end else begin
            if (gen_we) begin
                regs_q[ctrl_writeReg] <= data_writeReg;
            end
            sync1_q         <= external_inputs;
            sync2_q         <= sync1_q;
            ext_prev_q      <= sync2_q;
            evt_q           <= evt_d;
            export_update_q <= export_update_d;
        end
    end

    // Slot 0 is never written, so it reads back as zero without a special case
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
        if (bypass && (idx == ctrl_writeReg)) return data_writeReg;
        if (idx == EXT_IDX) return sync2_q;
        if (idx == EVT_IDX) return evt_q;
        return regs_q[idx];
    endfunction

    always_comb data_readRegA = read_port(ctrl_readRegA);
    always_comb data_readRegB = read_port(ctrl_readRegB);

    for (genvar k = 0; k < NUM_EXPORT; k++) begin : g_export
        assign export_bus[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[EXPORT_BASE + k];
    end

    assign export_update = export_update_q;
    assign event_pending = |evt_q;

endmodule

// File: tb/tb_mmio_regfile_p.sv
// Self-checking bench for mmio_regfile_p: default and scaled configurations side by side,
// directed register-map scenarios followed by randomized traffic against a behavioural model.
module tb_mmio_regfile_p;

    localparam int unsigned DW_C   [2] = '{32, 8};
    localparam int unsigned NR_C   [2] = '{32, 8};
    localparam int unsigned EXT_C  [2] = '{29, 6};
    localparam int unsigned EVT_C  [2] = '{30, 7};
    localparam int unsigned BASE_C [2] = '{10, 2};
    localparam int unsigned NEXP_C [2] = '{13, 2};

    logic        clk = 1'b0;
    logic        rst;
    logic        we  [2];
    logic [4:0]  wa  [2];
    logic [4:0]  raA [2];
    logic [4:0]  raB [2];
    logic [31:0] wd  [2];
    logic [31:0] ext [2];

    logic [31:0]  rdA0, rdB0;
    logic [7:0]   rdA1, rdB1;
    logic [415:0] eb0;
    logic [15:0]  eb1;
    logic [12:0]  eu0;
    logic [1:0]   eu1;
    logic         ep0, ep1;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_regfile_p #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .EXT_REG(29), .EVT_REG(30),
        .EXPORT_BASE(10), .NUM_EXPORT(13)
    ) u_dut0 (
        .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we[0]),
        .ctrl_writeReg(wa[0]), .data_writeReg(wd[0]),
        .ctrl_readRegA(raA[0]), .ctrl_readRegB(raB[0]),
        .data_readRegA(rdA0), .data_readRegB(rdB0),
        .external_inputs(ext[0]), .export_bus(eb0),
        .export_update(eu0), .event_pending(ep0)
    );

    mmio_regfile_p #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .EXT_REG(6), .EVT_REG(7),
        .EXPORT_BASE(2), .NUM_EXPORT(2)
    ) u_dut1 (
        .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we[1]),
        .ctrl_writeReg(wa[1][2:0]), .data_writeReg(wd[1][7:0]),
        .ctrl_readRegA(raA[1][2:0]), .ctrl_readRegB(raB[1][2:0]),
        .data_readRegA(rdA1), .data_readRegB(rdB1),
        .external_inputs(ext[1][7:0]), .export_bus(eb1),
        .export_update(eu1), .event_pending(ep1)
    );

    // Behavioural model: register contents, the raw input sampled at the last three edges
    // ([0] newest), the sticky event word and last cycle's export-write flags.
    logic [31:0] m_reg [2][32];
    logic [31:0] m_smp [2][3];
    logic [31:0] m_evt [2];
    logic [12:0] m_upd [2];

    function automatic logic [31:0] mask_of(input int c);
        return (c == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic bit writable(input int c, input logic [4:0] i);
        return (i != 5'd0) && (i != 5'(EXT_C[c])) && (i != 5'(EVT_C[c]));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 32; i++) m_reg[c][i] = '0;
            for (int i = 0; i < 3; i++) m_smp[c][i] = '0;
            m_evt[c] = '0;
            m_upd[c] = '0;
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            logic [31:0] rise, clr;
            // EXT_REG is the sample from two edges back; an event needs it 1 now and 0 one edge earlier
            rise = m_smp[c][1] & ~m_smp[c][2];
            clr  = (we[c] && wa[c] == 5'(EVT_C[c])) ? (wd[c] & mask_of(c)) : 32'd0;
            m_evt[c] = (m_evt[c] & ~clr) | rise;
            m_upd[c] = '0;
            if (we[c] && wa[c] >= 5'(BASE_C[c]) && wa[c] < 5'(BASE_C[c] + NEXP_C[c]))
                m_upd[c][wa[c] - 5'(BASE_C[c])] = 1'b1;
            if (we[c] && writable(c, wa[c])) m_reg[c][wa[c]] = wd[c] & mask_of(c);
            m_smp[c][2] = m_smp[c][1];
            m_smp[c][1] = m_smp[c][0];
            m_smp[c][0] = ext[c] & mask_of(c);
        end
    endtask

    function automatic logic [31:0] model_read(input int c, input logic [4:0] idx);
        if (rst) return '0;
        if (we[c] && idx == wa[c] && writable(c, wa[c])) return wd[c] & mask_of(c);
        if (idx == 5'd0) return '0;
        if (idx == 5'(EXT_C[c])) return m_smp[c][1];
        if (idx == 5'(EVT_C[c])) return m_evt[c];
        return m_reg[c][idx];
    endfunction

    function automatic logic [415:0] model_ebus(input int c);
        logic [415:0] e = '0;
        for (int k = 0; k < int'(NEXP_C[c]); k++)
            for (int b = 0; b < int'(DW_C[c]); b++)
                e[k * int'(DW_C[c]) + b] = m_reg[c][int'(BASE_C[c]) + k][b];
        return e;
    endfunction

    function automatic logic [31:0] o_rdA(input int c);
        return (c == 0) ? rdA0 : {24'd0, rdA1};
    endfunction
    function automatic logic [31:0] o_rdB(input int c);
        return (c == 0) ? rdB0 : {24'd0, rdB1};
    endfunction
    function automatic logic [415:0] o_eb(input int c);
        return (c == 0) ? eb0 : {400'd0, eb1};
    endfunction
    function automatic logic [31:0] o_eu(input int c);
        return (c == 0) ? {19'd0, eu0} : {30'd0, eu1};
    endfunction
    function automatic logic [31:0] o_ep(input int c);
        return (c == 0) ? {31'd0, ep0} : {31'd0, ep1};
    endfunction

    task automatic chk(input string tag, input logic [415:0] obs, input logic [415:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk(tag, {384'd0, obs}, {384'd0, exp});
    endtask

    task automatic check_all(input int c, input string tag);
        chk32({tag, "/rdA"}, o_rdA(c), model_read(c, raA[c]));
        chk32({tag, "/rdB"}, o_rdB(c), model_read(c, raB[c]));
        chk({tag, "/ebus"}, o_eb(c), model_ebus(c));
        chk32({tag, "/eupd"}, o_eu(c), {19'd0, m_upd[c]});
        chk32({tag, "/pend"}, o_ep(c), {31'd0, |m_evt[c]});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cfg(input int c);
        logic [31:0] m;
        logic [4:0]  ex, ev, b;
        string       p;
        m  = mask_of(c);
        ex = 5'(EXT_C[c]);
        ev = 5'(EVT_C[c]);
        b  = 5'(BASE_C[c]);
        p  = (c == 0) ? "c0" : "c1";

        // Bypass and hold, then writes to r0 discarded
        we[c] = 1'b1; wa[c] = 5'd5; wd[c] = 32'hDEAD_BEEF; raA[c] = 5'd5; raB[c] = 5'd0;
        #1;
        chk32({p, "/bypass"}, o_rdA(c), 32'hDEAD_BEEF & m);
        check_all(c, {p, "/bypass"});
        tick();
        we[c] = 1'b0;
        #1;
        chk32({p, "/hold"}, o_rdA(c), 32'hDEAD_BEEF & m);
        we[c] = 1'b1; wa[c] = 5'd0; wd[c] = 32'hFFFF_FFFF; raA[c] = 5'd0;
        #1;
        chk32({p, "/r0_byp"}, o_rdA(c), 32'd0);
        tick();
        we[c] = 1'b0;
        #1;
        chk32({p, "/r0_read"}, o_rdA(c), 32'd0);
        check_all(c, {p, "/r0"});

        // Export slice 1 and its single-cycle update pulse
        we[c] = 1'b1; wa[c] = b + 5'd1; wd[c] = 32'h12;
        tick();
        we[c] = 1'b0;
        #1;
        chk32({p, "/exp_slice"}, 32'(o_eb(c) >> DW_C[c]) & m, 32'h12);
        chk32({p, "/exp_upd"}, o_eu(c), 32'h2);
        check_all(c, {p, "/exp"});
        tick();
        chk32({p, "/exp_upd_clr"}, o_eu(c), 32'h0);

        // Synchroniser latency and event capture
        raA[c] = ex; raB[c] = ev; ext[c] = 32'h4;
        #1;
        check_all(c, {p, "/ext0"});
        tick();
        chk32({p, "/ext_e1"}, o_rdA(c), 32'h0);
        tick();
        chk32({p, "/ext_e2"}, o_rdA(c), 32'h4);
        chk32({p, "/evt_e2"}, o_rdB(c), 32'h0);
        tick();
        chk32({p, "/evt_e3"}, o_rdB(c), 32'h4);
        chk32({p, "/pend_e3"}, o_ep(c), 32'h1);
        check_all(c, {p, "/ext3"});

        // Writes to EXT_REG ignored, no bypass
        we[c] = 1'b1; wa[c] = ex; wd[c] = 32'hFFFF_FFFF;
        #1;
        chk32({p, "/ext_nobyp"}, o_rdA(c), 32'h4);
        tick();
        we[c] = 1'b0;
        #1;
        chk32({p, "/ext_nowr"}, o_rdA(c), 32'h4);

        // Write-one-to-clear, then clear colliding with a fresh rise
        we[c] = 1'b1; wa[c] = ev; wd[c] = 32'h4;
        #1;
        chk32({p, "/evt_nobyp"}, o_rdB(c), 32'h4);
        tick();
        we[c] = 1'b0;
        #1;
        chk32({p, "/w1c"}, o_rdB(c), 32'h0);
        chk32({p, "/w1c_pend"}, o_ep(c), 32'h0);
        ext[c] = 32'h0;
        repeat (3) tick();
        ext[c] = 32'h4;
        repeat (2) tick();
        we[c] = 1'b1; wa[c] = ev; wd[c] = 32'h4;
        tick();
        we[c] = 1'b0;
        #1;
        chk32({p, "/set_prio"}, o_rdB(c), 32'h4);
        chk32({p, "/set_prio_pend"}, o_ep(c), 32'h1);
        check_all(c, {p, "/prio"});

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            we[c]  = 1'($urandom_range(0, 1));
            wa[c]  = 5'($urandom_range(0, NR_C[c] - 1));
            wd[c]  = $urandom();
            raA[c] = ($urandom_range(0, 3) == 0) ? wa[c] : 5'($urandom_range(0, NR_C[c] - 1));
            raB[c] = 5'($urandom_range(0, NR_C[c] - 1));
            if ($urandom_range(0, 3) == 0) ext[c] = $urandom();
            #1;
            check_all(c, {p, "/rnd"});
            tick();
        end
        we[c] = 1'b0;
        #1;
        check_all(c, {p, "/rnd_end"});

        // Reset asserted mid-cycle with a write pending
        we[c] = 1'b1; wa[c] = 5'd3; wd[c] = 32'hA5A5_A5A5; raA[c] = 5'd3; raB[c] = b;
        #1;
        check_all(c, {p, "/pre_rst"});
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        chk32({p, "/rst_rdA"}, o_rdA(c), 32'h0);
        chk({p, "/rst_ebus"}, o_eb(c), 416'd0);
        chk32({p, "/rst_eupd"}, o_eu(c), 32'h0);
        chk32({p, "/rst_pend"}, o_ep(c), 32'h0);
        check_all(c, {p, "/rst_mid"});
        tick();
        we[c] = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk32({p, "/rst_lost"}, o_rdA(c), 32'h0);
        check_all(c, {p, "/post_rst"});
        tick();
        check_all(c, {p, "/post_rst1"});
    endtask

    initial begin
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            we[c] = 1'b0; wa[c] = '0; wd[c] = '0; ext[c] = '0;
            raA[c] = 5'd5; raB[c] = 5'(EXT_C[c]);
        end
        model_reset();
        #12;
        check_all(0, "c0/reset");
        check_all(1, "c1/reset");
        rst = 1'b0;
        tick();
        run_cfg(0);
        run_cfg(1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
